// File: rtl/cur_enc_pkg.sv
// Shared constants for the current-DAC select path (encoder side).
package cur_enc_pkg;

    localparam int SEL_W  = 16;
    localparam int CODE_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILTER = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Number of set bits in a select word; a legal word has exactly one.
    function automatic logic [4:0] sel_popcount(input logic [SEL_W-1:0] w);
        logic [4:0] n;
        n = 5'd0;
        for (int k = 0; k < SEL_W; k++) begin
            n = n + {4'd0, w[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cur_enc_onehot_enc.sv
// Combinational one-hot to binary encoder with a legality flag.
// The code is an OR of the indices of all set bits (no priority), so it is only
// meaningful when legal is high.
module onehot_enc
    import cur_enc_pkg::*;
(
    input  logic [SEL_W-1:0]  in_w,
    output logic [CODE_W-1:0] code,
    output logic              legal
);

    logic [CODE_W-1:0] code_s;

    // OR-tree encode: every set bit contributes its index.
    always_comb begin
        code_s = {CODE_W{1'b0}};
        for (int k = 0; k < SEL_W; k++) begin
            if (in_w[k]) begin
                code_s = code_s | CODE_W'(k);
            end else begin
                code_s = code_s;
            end
        end
    end

    assign code  = code_s;
    assign legal = (sel_popcount(in_w) == 5'd1);

endmodule

// File: rtl/cur_enc.sv
// One-hot current-select encoder: input register, stability filter, legality
// check, valid/ready hand-off of the code and a saturating reject counter.
module cur_enc
    import cur_enc_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              err_illegal,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int                CNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};
    localparam logic [SEL_W-1:0]  SEL_RST = SEL_W'(1);

    logic [SEL_W-1:0]  sel_q,       sel_d;
    logic [SEL_W-1:0]  last_word_q, last_word_d;
    logic [SEL_W-1:0]  cand_q,      cand_d;
    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CODE_W-1:0] code_q,      code_d;
    logic              valid_q,     valid_d;
    logic              err_q,       err_d;
    logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;
    logic              busy_q,      busy_d;

    logic [CODE_W-1:0] cand_code_s;
    logic              cand_legal_s;

    onehot_enc u_enc (
        .in_w  (cand_q),
        .code  (cand_code_s),
        .legal (cand_legal_s)
    );

    // Next-state logic: filter FSM, hand-off register and reject counter.
    always_comb begin
        sel_d       = sel_in;
        last_word_d = last_word_q;
        cand_d      = cand_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_q != last_word_q) begin
                    state_d = ST_FILTER;
                    cand_d  = sel_q;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILTER: begin
                if (sel_q == cand_q) begin
                    if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (cand_legal_s) begin
                        code_d      = cand_code_s;
                        valid_d     = 1'b1;
                        last_word_d = cand_q;
                        state_d     = ST_HOLD;
                    end else begin
                        // Remember the rejected word so it does not retrigger.
                        err_d       = 1'b1;
                        last_word_d = cand_q;
                        state_d     = ST_IDLE;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end
                end else if (sel_q == last_word_q) begin
                    // Short excursion that came back: a glitch, no output.
                    state_d = ST_IDLE;
                end else begin
                    cand_d = sel_q;
                    cnt_d  = CNT_ONE;
                end
            end
            ST_HOLD: begin
                // Input changes here are picked up later by the IDLE compare.
                if (code_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= SEL_RST;
            last_word_q <= SEL_RST;
            cand_q      <= SEL_RST;
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            code_q      <= {CODE_W{1'b0}};
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= {ERR_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            last_word_q <= last_word_d;
            cand_q      <= cand_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign err_illegal = err_q;
    assign err_cnt     = err_cnt_q;
    assign busy        = busy_q;

endmodule
